// File: rtl/dyn_delay_line.sv
// dyn_delay_line: tap-steerable clock-domain delay line.
// z(t) = a(t-1-tap). The tap is stepped one position per rising edge on move,
// or reloaded to DEL_VALUE by loadn. While a step settles, the output is frozen
// so that downstream capture logic never sees a glitch.
// Optional feature macro: DYN_DELAY_BYPASS_EN adds a bypass input. When that
// input is high, z is forced to the one-cycle path.
module dyn_delay_line #(
  parameter int WIDTH      = 1,
  parameter int MAX_DEL    = 15,
  parameter int DEL_VALUE  = 0,
  parameter int SETTLE_CYC = 2,
  localparam int TAP_W     = (MAX_DEL > 0) ? $clog2(MAX_DEL + 1) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic             loadn,
  input  logic             move,
  input  logic             direction,
`ifdef DYN_DELAY_BYPASS_EN
  input  logic             bypass,
`endif
  output logic [WIDTH-1:0] z,
  output logic [TAP_W-1:0] tap,
  output logic             cflag,
  output logic             busy
);

  localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC + 1) : 1;
  localparam logic [TAP_W-1:0] TAP_MAX  = TAP_W'(MAX_DEL);
  localparam logic [TAP_W-1:0] TAP_RST  = TAP_W'(DEL_VALUE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_STEP, S_SETTLE} state_t;

  state_t             state, state_nxt;
  logic [TAP_W-1:0]   tap_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               dir_q, dir_nxt;
  logic               move_q;
  logic               step_req;
  logic [WIDTH-1:0]   hist_p0 [MAX_DEL+1];

  // A step is requested only by a fresh rising edge on move, seen while idle and not loading
  assign step_req = move & ~move_q & (state == S_IDLE) & loadn;
  assign busy     = (state != S_IDLE);
  assign cflag    = ((tap == TAP_MAX) && !direction) || ((tap == '0) && direction);

  // Next-state logic for the tap-steering FSM; loadn overrides every transition
  always_comb begin
    state_nxt = state;
    tap_nxt   = tap;
    cnt_nxt   = cnt;
    dir_nxt   = dir_q;
    case (state)
      S_IDLE: begin
        if (step_req) begin
          state_nxt = S_STEP;
          dir_nxt   = direction;
        end
      end
      S_STEP: begin
        if (!dir_q && (tap < TAP_MAX)) begin
          tap_nxt = tap + 1'b1;
        end else if (dir_q && (tap > '0)) begin
          tap_nxt = tap - 1'b1;
        end
        state_nxt = S_SETTLE;
        cnt_nxt   = '0;
      end
      S_SETTLE: begin
        if (cnt == CNT_LAST) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
    if (!loadn) begin
      tap_nxt   = TAP_RST;
      state_nxt = S_IDLE;
      cnt_nxt   = '0;
    end
  end

  // Control registers: FSM state, tap, settle counter, latched direction, move history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      tap    <= TAP_RST;
      cnt    <= '0;
      dir_q  <= 1'b0;
      move_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      tap    <= tap_nxt;
      cnt    <= cnt_nxt;
      dir_q  <= dir_nxt;
      move_q <= move;
    end
  end

  // Stage p0: history shift register, advances every cycle regardless of FSM state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= MAX_DEL; i++) hist_p0[i] <= '0;
    end else begin
      hist_p0[0] <= a;
      for (int i = 1; i <= MAX_DEL; i++) hist_p0[i] <= hist_p0[i-1];
    end
  end

  // Stage p1: output tap select, frozen while a step is in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z <= '0;
`ifdef DYN_DELAY_BYPASS_EN
    end else if (bypass) begin
      z <= hist_p0[0];
`endif
    end else if (state == S_IDLE) begin
      z <= hist_p0[tap];
    end
  end

endmodule

// File: tb/tb_dyn_delay_line.sv
// Directed bench for dyn_delay_line (default parameters: WIDTH=1, MAX_DEL=15,
// DEL_VALUE=0, SETTLE_CYC=2). A table drives tap operations and checks tap,
// cflag, busy length and pulse latency. Hand sequences cover the multi-cycle
// corner cases: edges while busy, held move, loadn priority, reset mid-settle
// and the optional bypass path.
module tb_dyn_delay_line;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [0:0] a;
  logic       loadn;
  logic       move;
  logic       direction;
  logic [0:0] z;
  logic [3:0] tap;
  logic       cflag;
  logic       busy;
`ifdef DYN_DELAY_BYPASS_EN
  logic       bypass;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dyn_delay_line dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .loadn     (loadn),
    .move      (move),
    .direction (direction),
`ifdef DYN_DELAY_BYPASS_EN
    .bypass    (bypass),
`endif
    .z         (z),
    .tap       (tap),
    .cflag     (cflag),
    .busy      (busy)
  );

  typedef struct {
    int   op;         // 0 = move step, 1 = loadn pulse
    logic dir;
    int   reps;
    int   exp_tap;
    logic exp_cflag;
    int   exp_busy;   // busy cycles of the last operation
    int   exp_lat;    // pulse latency in cycles after the operation
  } vec_t;

  vec_t vt [10];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One move edge in direction dir; returns the number of busy cycles seen
  task automatic do_move(input logic dir, output int blen);
    int guard;
    direction = dir;
    move = 1'b1;
    @(negedge clk);
    move = 1'b0;
    blen = 0;
    guard = 0;
    while (busy && guard < 50) begin
      blen++;
      guard++;
      @(negedge clk);
    end
    if (guard >= 50) chk("move_timeout", guard, 0);
  endtask

  task automatic do_load();
    loadn = 1'b0;
    @(negedge clk);
    loadn = 1'b1;
    @(negedge clk);
  endtask

  // Drive a one-cycle pulse on a and count cycles until it appears on z
  task automatic measure_lat(output int lat);
    a = 1'b1;
    @(negedge clk);
    a = 1'b0;
    lat = -1;
    for (int i = 0; i < 30; i++) begin
      if (z == 1'b1 && lat < 0) lat = i;
      @(negedge clk);
    end
  endtask

  initial begin
    int lat;
    int blen;
    rst_n = 1'b0;
    a = '0;
    loadn = 1'b1;
    move = 1'b0;
    direction = 1'b0;
`ifdef DYN_DELAY_BYPASS_EN
    bypass = 1'b0;
`endif

    vt[0] = '{0, 1'b0, 1,  1,  1'b0, 3, 2};
    vt[1] = '{0, 1'b0, 1,  2,  1'b0, 3, 3};
    vt[2] = '{0, 1'b0, 1,  3,  1'b0, 3, 4};
    vt[3] = '{0, 1'b1, 1,  2,  1'b0, 3, 3};
    vt[4] = '{1, 1'b0, 1,  0,  1'b0, 0, 1};
    vt[5] = '{0, 1'b1, 1,  0,  1'b1, 3, 1};
    vt[6] = '{0, 1'b0, 15, 15, 1'b1, 3, 16};
    vt[7] = '{0, 1'b0, 1,  15, 1'b1, 3, 16};
    vt[8] = '{0, 1'b1, 1,  14, 1'b0, 3, 15};
    vt[9] = '{1, 1'b0, 1,  0,  1'b0, 0, 1};

    repeat (2) @(negedge clk);
    chk("rst_z", z, 0);
    chk("rst_tap", tap, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cflag", cflag, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    measure_lat(lat);
    chk("reset_latency", lat, 1);

    for (int k = 0; k < 10; k++) begin
      blen = 0;
      direction = vt[k].dir;
      if (vt[k].op == 0) begin
        for (int r = 0; r < vt[k].reps; r++) do_move(vt[k].dir, blen);
      end else begin
        do_load();
        blen = busy;
      end
      chk($sformatf("vec%0d_tap", k), tap, vt[k].exp_tap);
      chk($sformatf("vec%0d_cflag", k), cflag, vt[k].exp_cflag);
      chk($sformatf("vec%0d_busy", k), blen, vt[k].exp_busy);
      measure_lat(lat);
      chk($sformatf("vec%0d_lat", k), lat, vt[k].exp_lat);
    end

    // Second edge arriving while busy is dropped
    direction = 1'b0;
    move = 1'b1;
    @(negedge clk);
    move = 1'b0;
    @(negedge clk);
    move = 1'b1;
    @(negedge clk);
    move = 1'b0;
    repeat (8) @(negedge clk);
    chk("edge_while_busy_tap", tap, 1);
    chk("edge_while_busy_idle", busy, 0);

    // Move held high for 20 cycles yields one step
    move = 1'b1;
    repeat (20) @(negedge clk);
    chk("held_move_busy", busy, 0);
    move = 1'b0;
    repeat (4) @(negedge clk);
    chk("held_move_tap", tap, 2);

    // loadn coincident with a move edge: reload wins, no step
    do_load();
    for (int r = 0; r < 7; r++) do_move(1'b0, blen);
    chk("pre_load_tap", tap, 7);
    move = 1'b1;
    loadn = 1'b0;
    @(negedge clk);
    chk("load_prio_tap", tap, 0);
    chk("load_prio_busy", busy, 0);
    loadn = 1'b1;
    move = 1'b0;
    @(negedge clk);
    chk("load_prio_busy2", busy, 0);
    chk("load_prio_tap2", tap, 0);

    // Output freeze during settle, then async reset mid-settle
    a = 1'b1;
    repeat (3) @(negedge clk);
    chk("freeze_pre_z", z, 1);
    direction = 1'b0;
    move = 1'b1;
    a = 1'b0;
    @(negedge clk);
    move = 1'b0;
    @(negedge clk);
    chk("freeze_settle_busy", busy, 1);
    chk("freeze_settle_z", z, 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_z", z, 0);
    chk("async_rst_tap", tap, 0);
    chk("async_rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_rst_tap", tap, 0);
    chk("post_rst_busy", busy, 0);

`ifdef DYN_DELAY_BYPASS_EN
    for (int r = 0; r < 9; r++) do_move(1'b0, blen);
    chk("byp_tap", tap, 9);
    bypass = 1'b1;
    @(negedge clk);
    measure_lat(lat);
    chk("byp_on_lat", lat, 1);
    bypass = 1'b0;
    @(negedge clk);
    measure_lat(lat);
    chk("byp_off_lat", lat, 10);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
